// File: rtl/mm2st_stream_reader_pkg.sv
// Shared definitions for the memory-to-stream reader: CSR map, status layout,
// FSM encoding and the per-word byte stride.
package mm2st_stream_reader_pkg;

    localparam logic [1:0] CSR_SRC_ADDR = 2'd0;
    localparam logic [1:0] CSR_LENGTH   = 2'd1;
    localparam logic [1:0] CSR_CTRL     = 2'd2;
    localparam logic [1:0] CSR_SENT     = 2'd3;

    localparam int unsigned CTRL_START_BIT    = 0;
    localparam int unsigned CTRL_CLR_DONE_BIT = 1;

    localparam int unsigned WORD_STRIDE    = 16;
    localparam int unsigned WORD_ADDR_LSBS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_e;

    function automatic logic [31:0] status_word(input logic [7:0] level,
                                                input logic       done,
                                                input logic       busy);
        return {16'd0, level, 6'd0, done, busy};
    endfunction

endpackage

// File: rtl/mm2st_stream_reader_fifo.sv
// Show-ahead synchronous FIFO: head presents the oldest entry combinationally,
// and reads as zero while empty.
module stream_fifo_sync #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign level   = level_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/mm2st_stream_reader.sv
// Memory-to-stream reader: CSR slave, read-issue FSM with FIFO credit control,
// and a show-ahead response buffer feeding the Avalon-ST source.
module mm2st_stream_reader
    import mm2st_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              aso_valid,
    output logic [DATA_W-1:0] aso_data,
    input  logic              aso_ready
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_addr_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [31:0]       length_q;
    logic [31:0]       len_lat_q;
    logic [31:0]       issued_q;
    logic [31:0]       sent_q;
    logic [31:0]       outstanding_q;
    logic              done_q;
    logic [31:0]       avs_readdata_q;
    logic              avs_readdatavalid_q;

    logic              fifo_empty;
    logic              fifo_full;
    logic [LVL_W-1:0]  fifo_level;
    logic              idle;
    logic              start_req;
    logic              start_idle;
    logic              start_go;
    logic              clr_done;
    logic              rd_accept;
    logic              rsp_accept;
    logic              pop;
    logic              credit_ok;
    logic              drain_done;
    logic [31:0]       csr_rdata;

    assign idle       = (state_q == ST_IDLE);
    assign start_req  = avs_write && (avs_address == CSR_CTRL) && avs_writedata[CTRL_START_BIT];
    assign clr_done   = avs_write && (avs_address == CSR_CTRL) && avs_writedata[CTRL_CLR_DONE_BIT];
    assign start_idle = start_req && idle;
    assign start_go   = start_idle && (length_q != '0);
    assign rd_accept  = avm_read && !avm_waitrequest;
    assign rsp_accept = avm_readdatavalid && (outstanding_q != '0);
    assign pop        = aso_valid && aso_ready;
    assign drain_done = (state_q == ST_DRAIN) && (sent_q == len_lat_q);
    // Buffered plus in-flight words must fit, so every response has a slot.
    assign credit_ok  = (({1'b0, outstanding_q} + 33'(fifo_level)) < 33'(FIFO_DEPTH)) && !fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_go) state_d = ST_ISSUE;
            ST_ISSUE: if (rd_accept && (issued_q + 32'd1 == len_lat_q)) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        avm_read = (state_q == ST_ISSUE) && (issued_q < len_lat_q) && credit_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_addr_q    <= '0;
            length_q      <= '0;
            cur_addr_q    <= '0;
            len_lat_q     <= '0;
            issued_q      <= '0;
            sent_q        <= '0;
            outstanding_q <= '0;
            done_q        <= 1'b0;
        end else begin
            if (avs_write && (avs_address == CSR_SRC_ADDR)) begin
                src_addr_q <= ADDR_W'(avs_writedata) & ~ADDR_W'((1 << WORD_ADDR_LSBS) - 1);
            end
            if (avs_write && (avs_address == CSR_LENGTH)) begin
                length_q <= avs_writedata;
            end

            if (start_idle) begin
                cur_addr_q <= src_addr_q;
                len_lat_q  <= length_q;
                issued_q   <= '0;
                sent_q     <= '0;
            end else begin
                if (rd_accept) begin
                    cur_addr_q <= cur_addr_q + ADDR_W'(WORD_STRIDE);
                    issued_q   <= issued_q + 32'd1;
                end
                if (pop) begin
                    sent_q <= sent_q + 32'd1;
                end
            end

            case ({rd_accept, rsp_accept})
                2'b10:   outstanding_q <= outstanding_q + 32'd1;
                2'b01:   outstanding_q <= outstanding_q - 32'd1;
                default: outstanding_q <= outstanding_q;
            endcase

            if (start_idle && (length_q == '0)) begin
                done_q <= 1'b1;
            end else if (start_go) begin
                done_q <= 1'b0;
            end else if (drain_done) begin
                done_q <= 1'b1;
            end else if (clr_done) begin
                done_q <= 1'b0;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (avs_address)
            CSR_SRC_ADDR: csr_rdata = 32'(src_addr_q);
            CSR_LENGTH:   csr_rdata = length_q;
            CSR_CTRL:     csr_rdata = status_word(8'(fifo_level), done_q, !idle);
            CSR_SENT:     csr_rdata = sent_q;
            default:      csr_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata_q      <= '0;
            avs_readdatavalid_q <= 1'b0;
        end else begin
            avs_readdatavalid_q <= avs_read;
            if (avs_read) begin
                avs_readdata_q <= csr_rdata;
            end
        end
    end

    assign avs_readdata      = avs_readdata_q;
    assign avs_readdatavalid = avs_readdatavalid_q;
    assign avm_address       = cur_addr_q;
    assign aso_valid         = !fifo_empty;

    stream_fifo_sync #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_accept),
        .push_data (avm_readdata),
        .pop       (pop),
        .head      (aso_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_mm2st_stream_reader.sv
// Bench for mm2st_stream_reader: CSR vector table, fabric model with latency
// and stall injection, and a stream scoreboard.
module tb_mm2st_stream_reader;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        avs_address;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              avs_read;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest = 1'b0;
    logic [DATA_W-1:0] avm_readdata = '0;
    logic              avm_readdatavalid = 1'b0;
    logic              aso_valid;
    logic [DATA_W-1:0] aso_data;
    logic              aso_ready;

    always #5 clk = ~clk;

    mm2st_stream_reader #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .aso_valid         (aso_valid),
        .aso_data          (aso_data),
        .aso_ready         (aso_ready)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- fabric model ----------------
    int          cyc = 0;
    logic [31:0] mem_base = '0;
    int          lat = 2;
    int          due_q[$];
    logic [127:0] rdata_q[$];
    logic [31:0] addr_log[$];
    int          stall_idx = -1;
    int          stall_left = 0;
    int          stall_seen = 0;
    bit          stall_active = 0;
    logic [31:0] stall_addr = '0;
    bit          read_seen = 0;
    bit          reset_watch = 0;
    int          late_rsp = 0;
    bit          valid_after = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = (a - mem_base) >> 4;
        return {32'hC0DE0000 ^ a, a, 32'h5A5A0000 + k, 32'hA0 + k};
    endfunction

    function automatic logic [127:0] exp_word(input logic [31:0] base, input int k);
        logic [31:0] a;
        a = base + 32'(k * 16);
        return {32'hC0DE0000 ^ a, a, 32'h5A5A0000 + 32'(k), 32'hA0 + 32'(k)};
    endfunction

    always @(negedge clk) begin
        if (avm_read) read_seen = 1;
        if (stall_left > 0 && (stall_active || (addr_log.size() == stall_idx && avm_read))) begin
            stall_active = 1;
            avm_waitrequest = 1'b1;
            stall_left--;
            stall_seen++;
            check("stall_addr_hold", avm_address, stall_addr);
            check("stall_read_hold", avm_read, 1'b1);
            if (stall_left == 0) stall_active = 0;
        end else begin
            avm_waitrequest = 1'b0;
        end
        if (avm_read && !avm_waitrequest) begin
            addr_log.push_back(avm_address);
            due_q.push_back(cyc + lat);
            rdata_q.push_back(mem_word(avm_address));
        end
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = rdata_q.pop_front();
            void'(due_q.pop_front());
            if (reset_watch) late_rsp++;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata = '0;
        end
    end

    // ---------------- stream scoreboard ----------------
    logic [127:0] exp_q[$];
    int pops = 0;

    always @(negedge clk) begin
        if (aso_valid && aso_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stream_extra: got beat %0h expected no beat", aso_data);
            end else begin
                check("stream_beat", aso_data, exp_q.pop_front());
            end
        end
        if (reset_watch && aso_valid) valid_after = 1;
    end

    // ---------------- CSR helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read = 1'b1;
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        check("csr_rdvalid", avs_readdatavalid, 1'b1);
        d = avs_readdata;
    endtask

    task automatic start_xfer(input logic [31:0] base, input int len);
        mem_base = base;
        addr_log.delete();
        for (int k = 0; k < len; k++) exp_q.push_back(exp_word(base, k));
        csr_write(2'd0, base);
        csr_write(2'd1, 32'(len));
        csr_write(2'd2, 32'h1);
    endtask

    task automatic wait_done(input string name);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            csr_read(2'd2, s);
            n++;
        end while (!s[1] && n < 400);
        check({name, "_done"}, s[1], 1'b1);
    endtask

    task automatic check_addrs(input string name, input logic [31:0] base, input int len);
        check({name, "_nreads"}, addr_log.size(), len);
        for (int k = 0; k < len && k < addr_log.size(); k++)
            check({name, "_addr"}, addr_log[k], base + 32'(k * 16));
    endtask

    typedef struct {
        logic [1:0]  addr;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } csr_vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        csr_vec_t    tbl[6];
        logic [31:0] r;
        int          p0;
        int          n;

        tbl[0] = '{2'd0, 1'b1, 32'h1234567F, 32'h12345670};
        tbl[1] = '{2'd1, 1'b1, 32'h00000055, 32'h00000055};
        tbl[2] = '{2'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF0};
        tbl[3] = '{2'd3, 1'b1, 32'h0000FFFF, 32'h00000000};
        tbl[4] = '{2'd2, 1'b1, 32'h00000002, 32'h00000000};
        tbl[5] = '{2'd1, 1'b0, 32'h00000000, 32'h00000055};

        reset = 1'b1;
        avs_address = '0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_read = 1'b0;
        aso_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", avs_readdata, 0);
        check("rst_readdatavalid", avs_readdatavalid, 0);
        check("rst_avm_read", avm_read, 0);
        check("rst_avm_address", avm_address, 0);
        check("rst_aso_valid", aso_valid, 0);
        check("rst_aso_data", aso_data, 0);
        reset = 1'b0;
        csr_read(2'd2, r);
        check("rst_status", r, 32'h0);
        csr_read(2'd3, r);
        check("rst_sent", r, 32'h0);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].wr) csr_write(tbl[i].addr, tbl[i].wdata);
            csr_read(tbl[i].addr, r);
            check("csr_table", r, tbl[i].exp);
        end

        // basic transfer
        aso_ready = 1'b1;
        lat = 2;
        start_xfer(32'h1000, 4);
        check("start_avm_read", avm_read, 1'b1);
        check("start_avm_address", avm_address, 32'h1000);
        wait_done("basic");
        check_addrs("basic", 32'h1000, 4);
        csr_read(2'd2, r);
        check("basic_status", r, 32'h2);
        csr_read(2'd3, r);
        check("basic_sent", r, 32'd4);
        check("basic_sb_empty", exp_q.size(), 0);

        // backpressure
        aso_ready = 1'b0;
        start_xfer(32'h2000, 32);
        tick(50);
        check("bp_reads_capped", addr_log.size(), 16);
        csr_read(2'd2, r);
        check("bp_status_level", r, 32'h00001001);
        aso_ready = 1'b1;
        wait_done("bp");
        check_addrs("bp", 32'h2000, 32);
        csr_read(2'd3, r);
        check("bp_sent", r, 32'd32);
        check("bp_sb_empty", exp_q.size(), 0);

        // stall on the 2nd read
        stall_seen = 0;
        start_xfer(32'h1000, 4);
        stall_addr = 32'h1010;
        stall_idx = 1;
        stall_left = 5;
        wait_done("stall");
        check("stall_cycles", stall_seen, 5);
        check_addrs("stall", 32'h1000, 4);
        check("stall_sb_empty", exp_q.size(), 0);
        stall_idx = -1;

        // LENGTH = 0
        csr_write(2'd2, 32'h2);
        csr_read(2'd2, r);
        check("clr_done_status", r, 32'h0);
        read_seen = 0;
        csr_write(2'd1, 32'd0);
        csr_write(2'd2, 32'h1);
        csr_read(2'd2, r);
        check("len0_status", r, 32'h2);
        tick(5);
        check("len0_no_read", read_seen, 1'b0);
        csr_read(2'd3, r);
        check("len0_sent", r, 32'd0);

        // START while busy is ignored; register writes do not disturb the run
        aso_ready = 1'b0;
        start_xfer(32'h1000, 8);
        csr_write(2'd0, 32'h5000);
        csr_write(2'd1, 32'd3);
        csr_write(2'd2, 32'h1);
        tick(5);
        aso_ready = 1'b1;
        wait_done("busy");
        check_addrs("busy", 32'h1000, 8);
        csr_read(2'd3, r);
        check("busy_sent", r, 32'd8);
        csr_read(2'd0, r);
        check("busy_src_reg", r, 32'h5000);
        csr_read(2'd1, r);
        check("busy_len_reg", r, 32'd3);
        check("busy_sb_empty", exp_q.size(), 0);

        // address wrap
        start_xfer(32'hFFFFFFF0, 2);
        wait_done("wrap");
        check("wrap_nreads", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            check("wrap_addr0", addr_log[0], 32'hFFFFFFF0);
            check("wrap_addr1", addr_log[1], 32'h0);
        end
        check("wrap_sb_empty", exp_q.size(), 0);

        // reset after 3 beats
        lat = 4;
        aso_ready = 1'b1;
        p0 = pops;
        start_xfer(32'h3000, 8);
        n = 0;
        while (pops - p0 < 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_three_beats", pops - p0 >= 3, 1'b1);
        reset = 1'b1;
        aso_ready = 1'b0;
        @(posedge clk);
        #1;
        check("mid_readdata", avs_readdata, 0);
        check("mid_readdatavalid", avs_readdatavalid, 0);
        check("mid_avm_read", avm_read, 0);
        check("mid_avm_address", avm_address, 0);
        check("mid_aso_valid", aso_valid, 0);
        check("mid_aso_data", aso_data, 0);
        reset_watch = 1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        aso_ready = 1'b1;
        tick(20);
        check("mid_late_rsp_seen", late_rsp > 0, 1'b1);
        check("mid_no_valid", valid_after, 1'b0);
        reset_watch = 0;
        csr_read(2'd2, r);
        check("mid_status", r, 32'h0);
        csr_read(2'd3, r);
        check("mid_sent", r, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
